// File: rtl/tpu_pkg.sv
// Shared TPU definitions: collector FSM states and row-counter width.
package tpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } collector_state_e;

  localparam int ROW_CNT_W = 16;

endpackage

// File: rtl/output_deskew_collector_if.sv
// Skewed-column input bus and aligned-row output stream of the deskew collector.
// Handshake: a row moves downstream in any cycle where out_valid and out_ready
// are both high; while out_valid is high and out_ready is low, out_valid,
// data_out and out_last hold.  in_valid has no back-pressure.
interface output_deskew_collector_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16
);
  logic                                 in_valid;
  logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] data_in;
  logic                                 out_valid;
  logic                                 out_ready;
  logic                                 out_last;
  logic [ARRAY_SIZE-1:0][OUT_WIDTH-1:0] data_out;

  modport master (
    output in_valid, data_in, out_ready,
    input  out_valid, data_out, out_last
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output out_valid, data_out, out_last
  );
endinterface

// File: rtl/deskew_row_fifo.sv
// Show-ahead row FIFO with full/empty flags and simultaneous push/pop.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module deskew_row_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // next pointer values; clear wins over any push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // storage write; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/output_deskew_collector.sv
// Output deskew collector: realigns skewed systolic column outputs into rows,
// narrows each element to OUT_WIDTH and buffers rows for a ready/valid consumer.
// Optional feature macro: DESKEW_SATURATE_EN -- when defined, narrowing clamps
// to the signed OUT_WIDTH range; otherwise it keeps the low bits (wrap).
module output_deskew_collector
  import tpu_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ROW_CNT_W-1:0]   num_rows,
  input  logic                   flush,
  output_deskew_collector_if.slave bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output collector_state_e       state_dbg
);

  localparam int NSTG = ARRAY_SIZE - 1;
  localparam int EW   = ARRAY_SIZE * OUT_WIDTH + 1;

  logic [ACC_WIDTH-1:0]                 aligned_acc [ARRAY_SIZE];
  logic                                 aligned_valid;
  logic [ARRAY_SIZE-1:0][OUT_WIDTH-1:0] row_narrow;

  // ---------------- column deskew: column k gets NSTG-k stages ----------------
  for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_col
    localparam int NS = ARRAY_SIZE - 1 - k;
    if (NS == 0) begin : g_pass
      assign aligned_acc[k] = bus.data_in[k];
    end else begin : g_dly
      logic [ACC_WIDTH-1:0] pipe_q [NS];
      logic [ACC_WIDTH-1:0] pipe_d [NS];

      // shift column k toward row alignment; flush empties the chain
      always_comb begin
        for (int i = 0; i < NS; i++) pipe_d[i] = '0;
        if (!flush) begin
          pipe_d[0] = bus.data_in[k];
          for (int i = 1; i < NS; i++) pipe_d[i] = pipe_q[i-1];
        end
      end

      // column delay registers
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < NS; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign aligned_acc[k] = pipe_q[NS-1];
    end
  end

  // ---------------- valid delay matching the deepest column ----------------
  if (NSTG == 0) begin : g_vpass
    assign aligned_valid = bus.in_valid;
  end else begin : g_vdly
    logic vld_q [NSTG];
    logic vld_d [NSTG];

    // delay in_valid so it lands with the aligned row
    always_comb begin
      for (int i = 0; i < NSTG; i++) vld_d[i] = 1'b0;
      if (!flush) begin
        vld_d[0] = bus.in_valid;
        for (int i = 1; i < NSTG; i++) vld_d[i] = vld_q[i-1];
      end
    end

    // valid delay registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < NSTG; i++) vld_q[i] <= 1'b0;
      end else begin
        vld_q <= vld_d;
      end
    end

    assign aligned_valid = vld_q[NSTG-1];
  end

  // ---------------- narrowing ahead of FIFO storage ----------------
  function automatic logic [OUT_WIDTH-1:0] narrow(input logic [ACC_WIDTH-1:0] v);
`ifdef DESKEW_SATURATE_EN
    logic signed [ACC_WIDTH-1:0] sv;
    logic signed [ACC_WIDTH-1:0] lim_hi;
    logic signed [ACC_WIDTH-1:0] lim_lo;
    sv     = $signed(v);
    lim_hi = $signed({{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
    lim_lo = $signed({{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});
    if (sv > lim_hi)      narrow = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (sv < lim_lo) narrow = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                  narrow = v[OUT_WIDTH-1:0];
`else
    narrow = v[OUT_WIDTH-1:0];
`endif
  endfunction

  // narrow every aligned element
  always_comb begin
    row_narrow = '0;
    for (int k = 0; k < ARRAY_SIZE; k++) row_narrow[k] = narrow(aligned_acc[k]);
  end

  // ---------------- control ----------------
  collector_state_e       state_q, state_d;
  logic [ROW_CNT_W-1:0]   row_cnt_q, row_cnt_d;
  logic [ROW_CNT_W-1:0]   num_rows_q, num_rows_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                   is_last;
  logic [EW-1:0]          fifo_rdata;

  // next-state, row counting, push/drop decision
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    num_rows_d = num_rows_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = !fifo_empty && bus.out_ready;
    is_last    = (row_cnt_q == num_rows_q - 1'b1);
    if (flush) begin
      state_d   = ST_IDLE;
      row_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            row_cnt_d  = '0;
            ovf_d      = 1'b0;
            num_rows_d = num_rows;
            state_d    = (num_rows != '0) ? ST_COLLECT : ST_DRAIN;
          end
        end
        ST_COLLECT: begin
          if (aligned_valid) begin
            row_cnt_d = row_cnt_q + 1'b1;
            if (!fifo_full || fifo_pop) fifo_push = 1'b1;
            else                        ovf_d     = 1'b1;
            if (row_cnt_d == num_rows_q) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_cnt_q  <= '0;
      num_rows_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      num_rows_q <= num_rows_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  deskew_row_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (fifo_push),
    .wdata ({is_last, row_narrow}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // outputs are gated by empty so unwritten storage never reaches the port
  assign bus.out_valid = !fifo_empty;
  assign bus.data_out  = fifo_empty ? '0 : fifo_rdata[EW-2:0];
  assign bus.out_last  = !fifo_empty && fifo_rdata[EW-1];
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign overflow      = ovf_q;
  assign state_dbg     = state_q;

endmodule
